up_digital_display: RTL and testbench

Parametrised N-digit BCD up/down counter with a multiplexed seven-segment output stage. It is the successor of the single-digit Up_clk-driven display block: width and digit count are generalised, and it adds load, count direction, wrap flag, leading-zero blanking, and static or scanned digit selection. It sits between the board push-button/step logic and the segment/anode pins.

---
 rtl/up_digital_display_pkg.sv | 35 +++
 rtl/up_digital_display_if.sv | 28 ++
 rtl/up_digital_display_bcd_digit.sv | 31 +++
 rtl/up_digital_display.sv | 113 +++++++++++
 tb/tb_up_digital_display.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/up_digital_display_pkg.sv
// Shared types and seven-segment codes for the BCD display counter.
// Segment bit order is a..g in bits 0..6, dp in bit 7.
package up_display_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic logic [7:0] seg_code(bcd_t d);
    case (d)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/up_digital_display_if.sv
// Control/display bundle between the step logic and the display counter.
// master drives the controls and reads the display; slave is the counter.
interface up_digital_display_if #(
  parameter int DIGITS = 4,
  parameter int SEL_W  = 3
);
  logic                  Step;
  logic                  Dir;
  logic                  Load;
  logic [4*DIGITS-1:0]   Load_value;
  logic                  Mode;
  logic [SEL_W-1:0]      Choose_light;
  logic                  Blank_lz;
  logic [7:0]            Digital_light;
  logic [DIGITS-1:0]     Digit_en;
  logic [4*DIGITS-1:0]   Count_value;
  logic                  Wrap;

  modport master (
    output Step, Dir, Load, Load_value, Mode, Choose_light, Blank_lz,
    input  Digital_light, Digit_en, Count_value, Wrap
  );

  modport slave (
    input  Step, Dir, Load, Load_value, Mode, Choose_light, Blank_lz,
    output Digital_light, Digit_en, Count_value, Wrap
  );
endinterface

// File: rtl/up_digital_display_bcd_digit.sv
// One BCD digit of the counter chain: load, inc/dec, ripple carry/borrow.
// Register updates at the clock edge; cout is combinational from q and cin.
module up_bcd_digit
  import up_display_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  bcd_t load_val,
  input  logic step,
  input  logic up,
  input  logic cin,
  output bcd_t q,
  output logic cout
);

  // cin means every lower digit is rolling over, so this one moves too
  assign cout = cin && (up ? (q == 4'd9) : (q == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (load) begin
      q <= (load_val > 4'd9) ? 4'd0 : load_val;
    end else if (step && cin) begin
      if (up) q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
      else    q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
  end

endmodule

// File: rtl/up_digital_display.sv
// N-digit BCD up/down counter with registered static/scanned seven-segment output.
// Count_value moves at the step-detect edge; segment/enable outputs lag their sources by one cycle.
module up_digital_display
  import up_display_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_W          = 3
) (
  input  logic Up_clk,
  input  logic Up_reset,
  up_digital_display_if.slave io
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [7:0]        LIGHT_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] EN_POL    = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  logic                step_d;
  logic                step_ev;
  wire  [DIGITS:0]     carry;
  wire  [3:0]          cnt [DIGITS];
  logic [4*DIGITS-1:0] count_flat;
  logic                wrap_q;
  logic [DIV_W-1:0]    div;
  logic [SEL_W-1:0]    idx;
  logic [SEL_W-1:0]    sel;
  bcd_t                nib;
  int                  msnz;
  logic                blank;
  logic [7:0]          light_nx;
  logic [DIGITS-1:0]   en_nx;
  logic [7:0]          light_q;
  logic [DIGITS-1:0]   en_q;

  assign step_ev  = io.Step && !step_d;
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    up_bcd_digit u_digit (
      .clk      (Up_clk),
      .rst_n    (Up_reset),
      .load     (io.Load),
      .load_val (io.Load_value[4*g +: 4]),
      .step     (step_ev),
      .up       (io.Dir),
      .cin      (carry[g]),
      .q        (cnt[g]),
      .cout     (carry[g+1])
    );
  end

  always_comb begin
    count_flat = '0;
    for (int i = 0; i < DIGITS; i++) count_flat[4*i +: 4] = cnt[i];
  end

  always_ff @(posedge Up_clk or negedge Up_reset) begin
    if (!Up_reset) begin
      step_d <= 1'b0;
      wrap_q <= 1'b0;
      div    <= '0;
      idx    <= '0;
    end else begin
      step_d <= io.Step;
      wrap_q <= !io.Load && step_ev && carry[DIGITS];
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= (idx == SEL_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Digit mux plus leading-zero detect; an out-of-range static select lights nothing
  always_comb begin
    sel   = io.Mode ? idx : io.Choose_light;
    nib   = 4'd0;
    msnz  = 0;
    en_nx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt[i] != 4'd0) msnz = i;
      if (int'(sel) == i) begin
        nib      = cnt[i];
        en_nx[i] = 1'b1;
      end
    end
    blank    = io.Blank_lz && (int'(sel) > msnz);
    light_nx = SEG_BLANK;
    if (int'(sel) < DIGITS) begin
      light_nx    = blank ? SEG_BLANK : seg_code(nib);
      light_nx[7] = io.Mode && (idx == io.Choose_light);
    end
  end

  always_ff @(posedge Up_clk or negedge Up_reset) begin
    if (!Up_reset) begin
      light_q <= SEG_0 ^ LIGHT_POL;
      en_q    <= DIGITS'(1) ^ EN_POL;
    end else begin
      light_q <= light_nx ^ LIGHT_POL;
      en_q    <= en_nx ^ EN_POL;
    end
  end

  assign io.Digital_light = light_q;
  assign io.Digit_en      = en_q;
  assign io.Count_value   = count_flat;
  assign io.Wrap          = wrap_q;

endmodule

// File: tb/tb_up_digital_display.sv
// Directed and random stimulus against an arithmetic reference model of the display counter.
// Extra 3-digit instances cover out-of-range select in both output polarities.
module tb_up_digital_display;

  localparam int D  = 4;
  localparam int SD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] codes [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // model state: count as a plain integer, edges since reset, last Step
  int   mval;
  int   mn;
  logic mprev;
  logic [7:0] exp_light;
  logic [3:0] exp_en;
  logic       exp_wrap;

  always #5 clk = ~clk;

  up_digital_display_if #(.DIGITS(D), .SEL_W(3)) bus ();
  up_digital_display_if #(.DIGITS(3), .SEL_W(2)) b3 ();
  up_digital_display_if #(.DIGITS(3), .SEL_W(2)) b3n ();

  up_digital_display #(.DIGITS(D), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(0), .SEL_W(3)) dut (
    .Up_clk(clk), .Up_reset(rst_n), .io(bus));
  up_digital_display #(.DIGITS(3), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(0), .SEL_W(2)) dut3 (
    .Up_clk(clk), .Up_reset(rst_n), .io(b3));
  up_digital_display #(.DIGITS(3), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .SEL_W(2)) dut3n (
    .Up_clk(clk), .Up_reset(rst_n), .io(b3n));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic int load_int(input logic [15:0] lv);
    int v = 0;
    int nb;
    for (int i = D - 1; i >= 0; i--) begin
      nb = int'(lv[4*i +: 4]);
      v  = v * 10 + ((nb > 9) ? 0 : nb);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic disp(input int v, input logic mode, input logic [2:0] cl, input logic blz,
                      input int idx, output logic [3:0] en, output logic [7:0] light);
    int sel;
    int digit;
    sel   = mode ? idx : int'(cl);
    en    = '0;
    light = 8'h00;
    if (sel < D) begin
      en    = 4'(1 << sel);
      digit = (v / pow10(sel)) % 10;
      // a digit is a leading zero when the whole value fits below it
      if (!(blz && sel > 0 && v < pow10(sel))) light = codes[digit];
      light[7] = mode && (idx == int'(cl));
    end
  endtask

  task automatic model_reset();
    mval = 0; mn = 0; mprev = 1'b0;
  endtask

  task automatic tick();
    int   maxv;
    logic ev;
    maxv = pow10(D) - 1;
    disp(mval, bus.Mode, bus.Choose_light, bus.Blank_lz, (mn / SD) % D, exp_en, exp_light);
    ev = bus.Step && !mprev;
    exp_wrap = 1'b0;
    if (bus.Load) begin
      mval = load_int(bus.Load_value);
    end else if (ev) begin
      if (bus.Dir) begin
        if (mval == maxv) begin mval = 0; exp_wrap = 1'b1; end
        else mval = mval + 1;
      end else begin
        if (mval == 0) begin mval = maxv; exp_wrap = 1'b1; end
        else mval = mval - 1;
      end
    end
    mprev = bus.Step;
    mn = mn + 1;
    @(posedge clk);
    #1;
    chk("count", 32'(bus.Count_value), 32'(to_bcd(mval)));
    chk("wrap",  32'(bus.Wrap),        32'(exp_wrap));
    chk("light", 32'(bus.Digital_light), 32'(exp_light));
    chk("en",    32'(bus.Digit_en),    32'(exp_en));
  endtask

  task automatic step_pulse();
    bus.Step = 1'b1; tick();
    bus.Step = 1'b0; tick();
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.Load = 1'b1; bus.Load_value = v; tick();
    bus.Load = 1'b0;
  endtask

  initial begin
    bus.Step = 0; bus.Dir = 1; bus.Load = 0; bus.Load_value = '0;
    bus.Mode = 0; bus.Choose_light = 0; bus.Blank_lz = 0;
    b3.Step = 0; b3.Dir = 1; b3.Load = 0; b3.Load_value = '0;
    b3.Mode = 0; b3.Choose_light = 2'd3; b3.Blank_lz = 0;
    b3n.Step = 0; b3n.Dir = 1; b3n.Load = 0; b3n.Load_value = '0;
    b3n.Mode = 0; b3n.Choose_light = 2'd3; b3n.Blank_lz = 0;

    #12;
    chk("rst_count", 32'(bus.Count_value), 32'h0000);
    chk("rst_light", 32'(bus.Digital_light), 32'h3F);
    chk("rst_en",    32'(bus.Digit_en), 32'b0001);
    chk("rst_wrap",  32'(bus.Wrap), 32'h0);
    chk("rst3n_light", 32'(b3n.Digital_light), 32'hC0);
    chk("rst3n_en",    32'(b3n.Digit_en), 32'b110);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // three single-cycle steps, static digit 0
    step_pulse(); step_pulse(); step_pulse();
    chk("cnt3", 32'(bus.Count_value), 32'h0003);
    chk("seg3", 32'(bus.Digital_light), 32'h4F);

    // out-of-range static select on 3-digit instances
    chk("d3_oor_en",     32'(b3.Digit_en), 32'b000);
    chk("d3_oor_light",  32'(b3.Digital_light), 32'h00);
    chk("d3n_oor_en",    32'(b3n.Digit_en), 32'b111);
    chk("d3n_oor_light", 32'(b3n.Digital_light), 32'hFF);
    b3.Choose_light = 2'd1; b3n.Choose_light = 2'd1;
    tick();
    chk("d3_sel1_en",     32'(b3.Digit_en), 32'b010);
    chk("d3_sel1_light",  32'(b3.Digital_light), 32'h3F);
    chk("d3n_sel1_en",    32'(b3n.Digit_en), 32'b101);
    chk("d3n_sel1_light", 32'(b3n.Digital_light), 32'hC0);

    // wrap up then wrap down
    do_load(16'h9999);
    bus.Step = 1'b1; tick();
    chk("wrap_up", 32'(bus.Wrap), 32'h1);
    chk("wrap_up_cnt", 32'(bus.Count_value), 32'h0000);
    bus.Step = 1'b0; tick();
    chk("wrap_up_end", 32'(bus.Wrap), 32'h0);
    bus.Dir = 1'b0;
    bus.Step = 1'b1; tick();
    chk("wrap_dn", 32'(bus.Wrap), 32'h1);
    chk("wrap_dn_cnt", 32'(bus.Count_value), 32'h9999);
    bus.Step = 1'b0; tick();
    chk("wrap_dn_end", 32'(bus.Wrap), 32'h0);

    // held Step gives one event
    bus.Dir = 1'b1;
    do_load(16'h0000);
    bus.Step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.Step = 1'b0; tick();
    chk("held_step", 32'(bus.Count_value), 32'h0001);

    // load beats a coincident step event; invalid nibble loads as zero
    bus.Load = 1'b1; bus.Load_value = 16'h0042; bus.Step = 1'b1; tick();
    bus.Load = 1'b0; bus.Step = 1'b0;
    chk("load_prio", 32'(bus.Count_value), 32'h0042);
    do_load(16'h00A5);
    chk("load_bad_nib", 32'(bus.Count_value), 32'h0005);

    // scan with leading-zero blanking and dp cursor on digit 3
    do_load(16'h0102);
    bus.Mode = 1'b1; bus.Blank_lz = 1'b1; bus.Choose_light = 3'd3;
    for (int i = 0; i < 20; i++) tick();

    // async reset between clocks, mid-count
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.Count_value), 32'h0000);
    chk("arst_light", 32'(bus.Digital_light), 32'h3F);
    chk("arst_en",    32'(bus.Digit_en), 32'b0001);
    chk("arst_wrap",  32'(bus.Wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.Mode = 1'b0; bus.Blank_lz = 1'b0; bus.Choose_light = 3'd0;
    tick();

    // random traffic, including loads near the wrap points
    for (int i = 0; i < 600; i++) begin
      bus.Step = 1'($urandom_range(0, 1));
      bus.Dir  = 1'($urandom_range(0, 1));
      bus.Load = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       bus.Load_value = 16'h9999;
        1:       bus.Load_value = 16'h0000;
        default: bus.Load_value = 16'($urandom());
      endcase
      if ($urandom_range(0, 7) == 0) bus.Mode = ~bus.Mode;
      bus.Choose_light = 3'($urandom_range(0, 7));
      bus.Blank_lz = 1'($urandom_range(0, 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
